psk8_symbol_detector: RTL
=========================

Name: psk8_symbol_detector

Overview:
- Receive-side counterpart of the 8-PSK modulator. Takes the 8-bit sampled carrier produced by the DDS and recovers the 3-bit symbol (phase offset 0..7 = 0..315 deg in 45 deg steps).
- Finds the peak sample position in each carrier period and compares it with the phase-0 peak position.
- Checks consistency across the periods of one symbol, emits a one-cycle symbol strobe, and maintains a lock flag.

Parameters:
- N_SAMP, 8: samples per carrier period; must be 8*2^m (m >= 0).
- PERIODS_PER_SYM, 4: carrier periods per symbol; must be >= 1.
- REF_PEAK, 2: sample index (0..N_SAMP-1) of the peak at phase offset 0.
- MIN_PEAK, 200: minimum acceptable period maximum (unsigned). A lower maximum flags an amplitude error.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- sample_in  input  8  unsigned offset-binary carrier sample (128 = zero).
- sample_valid  input  1  sample_in is valid this cycle.
- sync_in  input  1  symbol-boundary marker; a valid sample with sync_in=1 is index 0 of period 0.
- sym_out  output  3  recovered symbol.
- sym_valid  output  1  one-cycle strobe; sym_out and sym_err are valid.
- sym_err  output  1  symbol inconsistent or amplitude too low.
- locked  output  1  high after an error-free symbol.

Behaviour:
Reset:
- rst low at any time (including mid-symbol) immediately clears all counters, max/argmax registers, and the mismatch and amplitude flags.
- Outputs go to sym_out=0, sym_valid=0, sym_err=0, locked=0.
- The FSM returns to IDLE.

FSM states:
- IDLE: wait for sample_valid && sync_in; that sample is accepted as index 0 of period 0 and the FSM moves to MEASURE. Valid samples without sync_in are ignored.
- MEASURE: each valid sample advances samp_idx (0..N_SAMP-1, wraps). When samp_idx wraps, per_idx advances (0..PERIODS_PER_SYM-1). Cycles with sample_valid=0 freeze all state.
- When the last sample of the last period is accepted, the decision is registered and the FSM loops to MEASURE for the next symbol. There is no dead cycle: the next valid sample is index 0 of period 0.

Period processing:
- Per period, track max and argmax. Comparison is strictly greater, so ties keep the earliest index.
- Index 0 loads max/argmax unconditionally.
- Period decision uses the final max/argmax including the current sample, computed combinationally on the last sample:
  - d = ((REF_PEAK - argmax) mod N_SAMP) >> m, in 3-bit modulo arithmetic.
  - If the final max < MIN_PEAK, set amp_err.
- Period 0's decision is stored as sym_ref. Each later period whose d != sym_ref sets mismatch.

Output timing:
- sym_valid pulses high for exactly one cycle, on the clock edge after the edge that accepted the last sample of the symbol.
- Latency is 1 cycle.
- sym_out = last period's decision; sym_err = mismatch | amp_err.
- mismatch and amp_err clear when the next symbol starts.
- sym_out holds its value between strobes.

Lock:
- locked is set on a strobe with sym_err=0 and cleared on a strobe with sym_err=1.
- locked also clears on any mid-symbol resync.

Resync:
- sync_in=1 with sample_valid=1 while in MEASURE at samp_idx or per_idx != 0 abandons the partial symbol.
- The abandoned symbol produces no strobe; flags are cleared and locked is cleared.
- The current sample becomes index 0 of period 0.
- sync_in exactly on a natural symbol boundary is a no-op.
- sync_in without sample_valid is ignored.

Simultaneous events:
- A strobe from the previous symbol and acceptance of the next symbol's first sample occur in the same cycle; both take effect.

Widths:
- samp_idx is $clog2(N_SAMP) bits; per_idx is max(1, $clog2(PERIODS_PER_SYM)) bits.
- The subtraction is done in $clog2(N_SAMP) bits, so wrap-around is inherent.

Test Plan:
- Defaults, phase 0: after rst release, sync on first sample, 4 periods of 128,218,255,218,128,38,1,38 → one strobe one cycle after the 32nd sample; sym_out=0, sym_err=0, locked=1.
- All 8 phases: back-to-back symbols with sample[i] = LUT[(i+k) mod 8] for k=0..7, no gaps → strobes every 32 cycles; sym_out=k each time; locked stays 1; e.g. k=3 has its peak at index 7.
- Phase change within a symbol: periods 0-1 at k=2, periods 2-3 at k=5 → sym_out=5, sym_err=1, locked falls to 0 on that strobe.
- Low amplitude: samples 128±50 (max 178 < 200) at k=1 → sym_out=1, sym_err=1.
- Gaps and resync: sample_valid low for 3 cycles mid-period → strobe delayed exactly 3 cycles, result unchanged. sync_in at sample 13 → no strobe for the partial symbol, next strobe 32 valid samples after the resync, locked=0 until that strobe.
- Async reset mid-symbol: rst low between clock edges at sample 20 → outputs zero immediately without waiting for an edge; after release, no strobe until a new sync plus 32 samples.

Source files
------------

// File: rtl/psk8_symbol_detector.sv
// 8-PSK symbol detector: locates the per-period peak of the sampled carrier,
// converts its offset from the phase-0 peak into a 3-bit symbol and checks consistency.
module psk8_symbol_detector #(
  parameter int N_SAMP          = 8,
  parameter int PERIODS_PER_SYM = 4,
  parameter int REF_PEAK        = 2,
  parameter int MIN_PEAK        = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       sync_in,
  output logic [2:0] sym_out,
  output logic       sym_valid,
  output logic       sym_err,
  output logic       locked
);

  localparam int SW = $clog2(N_SAMP);
  localparam int PW = (PERIODS_PER_SYM > 1) ? $clog2(PERIODS_PER_SYM) : 1;
  localparam int M  = SW - 3;
  localparam logic [SW-1:0] LAST_SAMP  = SW'(N_SAMP - 1);
  localparam logic [PW-1:0] LAST_PER   = PW'(PERIODS_PER_SYM - 1);
  localparam logic [SW-1:0] REF_IDX    = SW'(REF_PEAK);
  localparam logic [8:0]    MIN_PEAK_V = 9'(MIN_PEAK);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   samp_idx_q, samp_idx_d;
  logic [PW-1:0]   per_idx_q, per_idx_d;
  logic [7:0]      max_q, max_d;
  logic [SW-1:0]   argmax_q, argmax_d;
  logic [2:0]      sym_ref_q, sym_ref_d;
  logic            mismatch_q, mismatch_d;
  logic            amp_err_q, amp_err_d;
  logic [2:0]      sym_out_q, sym_out_d;
  logic            sym_valid_q, sym_valid_d;
  logic            sym_err_q, sym_err_d;
  logic            locked_q, locked_d;

  logic            accept, restart, resync;
  logic [SW-1:0]   eff_samp;
  logic [PW-1:0]   eff_per;
  logic [7:0]      cur_max;
  logic [SW-1:0]   cur_arg;
  logic [SW-1:0]   diff;
  logic [2:0]      dec;
  logic            period_end, sym_end, amp_now, mm_now, mm_base, amp_base;

  always_comb begin
    accept  = sample_valid && (state_q == MEASURE || sync_in);
    // A sync that lands on a natural symbol boundary is indistinguishable from no sync.
    restart = sample_valid && sync_in &&
              (state_q == IDLE || samp_idx_q != '0 || per_idx_q != '0);
    resync  = restart && (state_q == MEASURE);

    eff_samp = restart ? '0 : samp_idx_q;
    eff_per  = restart ? '0 : per_idx_q;
    mm_base  = restart ? 1'b0 : mismatch_q;
    amp_base = restart ? 1'b0 : amp_err_q;

    if (eff_samp == '0 || sample_in > max_q) begin
      cur_max = sample_in;
      cur_arg = eff_samp;
    end else begin
      cur_max = max_q;
      cur_arg = argmax_q;
    end

    diff       = REF_IDX - cur_arg;
    dec        = 3'(diff >> M);
    period_end = (eff_samp == LAST_SAMP);
    sym_end    = period_end && (eff_per == LAST_PER);
    amp_now    = period_end && ({1'b0, cur_max} < MIN_PEAK_V);
    mm_now     = period_end && (eff_per != '0) && (dec != sym_ref_q);
  end

  always_comb begin
    state_d     = state_q;
    samp_idx_d  = samp_idx_q;
    per_idx_d   = per_idx_q;
    max_d       = max_q;
    argmax_d    = argmax_q;
    sym_ref_d   = sym_ref_q;
    mismatch_d  = mismatch_q;
    amp_err_d   = amp_err_q;
    sym_out_d   = sym_out_q;
    sym_valid_d = 1'b0;
    sym_err_d   = sym_err_q;
    locked_d    = locked_q;

    if (accept) begin
      state_d    = MEASURE;
      max_d      = cur_max;
      argmax_d   = cur_arg;
      mismatch_d = mm_base | mm_now;
      amp_err_d  = amp_base | amp_now;
      if (period_end) begin
        samp_idx_d = '0;
        per_idx_d  = (eff_per == LAST_PER) ? '0 : eff_per + PW'(1);
      end else begin
        samp_idx_d = eff_samp + SW'(1);
        per_idx_d  = eff_per;
      end
      if (period_end && eff_per == '0) sym_ref_d = dec;
      if (resync) locked_d = 1'b0;
      // Flags are consumed here, so the following sample already starts clean.
      if (sym_end) begin
        sym_valid_d = 1'b1;
        sym_out_d   = dec;
        sym_err_d   = mismatch_d | amp_err_d;
        locked_d    = ~(mismatch_d | amp_err_d);
        mismatch_d  = 1'b0;
        amp_err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      samp_idx_q  <= '0;
      per_idx_q   <= '0;
      max_q       <= '0;
      argmax_q    <= '0;
      sym_ref_q   <= '0;
      mismatch_q  <= 1'b0;
      amp_err_q   <= 1'b0;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      sym_err_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_idx_q  <= samp_idx_d;
      per_idx_q   <= per_idx_d;
      max_q       <= max_d;
      argmax_q    <= argmax_d;
      sym_ref_q   <= sym_ref_d;
      mismatch_q  <= mismatch_d;
      amp_err_q   <= amp_err_d;
      sym_out_q   <= sym_out_d;
      sym_valid_q <= sym_valid_d;
      sym_err_q   <= sym_err_d;
      locked_q    <= locked_d;
    end
  end

  assign sym_out   = sym_out_q;
  assign sym_valid = sym_valid_q;
  assign sym_err   = sym_err_q;
  assign locked    = locked_q;

endmodule
